// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and mode constants for the shift sequencer
// Purpose : sequencer state encoding and shifter mode codes.
// Contents: seq_state_t (IDLE/SHIFT/DONE, 2 bits), MODE_* constants.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

   // 3'b100 aliases MODE_SHL0 and 3'b111 aliases MODE_ROR.
   localparam logic [2:0] MODE_SHL0 = 3'b000;
   localparam logic [2:0] MODE_SHL1 = 3'b001;
   localparam logic [2:0] MODE_SHR0 = 3'b010;
   localparam logic [2:0] MODE_SHR1 = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ROL  = 3'b110;

endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - single-step 4-bit combinational shifter/rotator
// Purpose : one shift or rotate step on a 4-bit value.
// Ports   : a    in  4  operand
//           mode in  3  operation select (see shift_pkg MODE_*)
//           r    out 4  result
import shift_pkg::*;

module shifter (
   input  logic [3:0] a,
   input  logic [2:0] mode,
   output logic [3:0] r
);

   always_comb begin
      r = a;
      case (mode)
         MODE_SHL0, 3'b100: r = {a[2:0], 1'b0};
         MODE_SHL1:         r = {a[2:0], 1'b1};
         MODE_SHR0:         r = {1'b0, a[3:1]};
         MODE_SHR1:         r = {1'b1, a[3:1]};
         MODE_ROL:          r = {a[2:0], a[3]};
         default:           r = {a[0], a[3:1]};   // MODE_ROR and 3'b111
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-step shift/rotate sequencer around the shifter
// Purpose : loads an operand, applies the shifter `count` times, strobes done.
// Ports   : clk       in  1      rising-edge clock
//           rst_n     in  1      asynchronous active-low reset
//           start     in  1      request, sampled only in IDLE
//           load_data in  4      operand captured on accepted start
//           mode      in  3      shifter mode captured on accepted start
//           count     in  CNT_W  step count captured on accepted start
//           q         out 4      holding register (current/final result)
//           busy      out 1      high in SHIFT and DONE
//           done      out 1      one-cycle strobe, q final while high
import shift_pkg::*;

module shift_sequencer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       load_data,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] count,
   output logic [3:0]       q,
   output logic             busy,
   output logic             done
);

   seq_state_t       r_state;
   logic [3:0]       r_q;
   logic [2:0]       r_mode;
   logic [CNT_W-1:0] r_rem;

   seq_state_t       w_state_nxt;
   logic [3:0]       w_q_nxt;
   logic [2:0]       w_mode_nxt;
   logic [CNT_W-1:0] w_rem_nxt;
   logic [3:0]       w_shift_r;

   shifter u_shifter (
      .a    (r_q),
      .mode (r_mode),
      .r    (w_shift_r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_q     <= 4'b0000;
         r_mode  <= 3'b000;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_mode  <= w_mode_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_mode_nxt  = r_mode;
      w_rem_nxt   = r_rem;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_q_nxt     = load_data;
               w_mode_nxt  = mode;
               w_rem_nxt   = count;
               w_state_nxt = (count == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // rem is at least 1 here, so the decrement never wraps.
            w_q_nxt   = w_shift_r;
            w_rem_nxt = r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign q    = r_q;
   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard testbench for shift_sequencer
module tb_shift_sequencer;

   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [3:0]       load_data = 4'd0;
   logic [2:0]       mode = 3'd0;
   logic [CNT_W-1:0] count = '0;
   logic [3:0]       q;
   logic             busy;
   logic             done;

   shift_sequencer #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .load_data (load_data),
      .mode      (mode),
      .count     (count),
      .q         (q),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] q;
      logic       dn;
   } tr_t;

   typedef struct {
      logic [3:0] q;
      int         cyc;
   } sb_t;

   tr_t        trace_q[$];
   sb_t        sb_q[$];
   int         n_cmp = 0;
   int         n_fail = 0;
   int         n_done = 0;
   int         n_exp_done = 0;
   int         cyc = 0;
   logic [3:0] exp_idle_q = 4'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: one step of the shifter written with plain arithmetic.
   function automatic int m_step(input int v, input int md);
      case (md)
         0, 4:    return (v * 2) % 16;
         1:       return (v * 2) % 16 + 1;
         2:       return v / 2;
         3:       return v / 2 + 8;
         6:       return (v * 2) % 16 + v / 8;
         default: return v / 2 + (v % 2) * 8;
      endcase
   endfunction

   // Monitor: every cycle out of reset, compare outputs against the expected trace.
   always @(negedge clk) begin
      tr_t te;
      sb_t se;
      if (rst_n) begin
         if (trace_q.size() > 0) begin
            te = trace_q.pop_front();
            check("busy", busy, 1);
            check("q_trace", q, te.q);
            check("done_flag", done, te.dn);
            if (done) begin
               n_done++;
               if (sb_q.size() == 0) begin
                  check("sb_nonempty", 0, 1);
               end else begin
                  se = sb_q.pop_front();
                  check("done_q", q, se.q);
                  check("done_cycle", cyc, se.cyc);
                  exp_idle_q = se.q;
               end
            end
         end else begin
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_q", q, exp_idle_q);
         end
      end
   end

   // Caller is aligned just after a negedge; issues one operation and waits it out.
   // inj_k >= 0 pulses a conflicting start at that negedge of the busy period.
   task automatic run_op(input int ld, input int md, input int cnt, input int gap, input int inj_k);
      int  v;
      int  e0;
      sb_t se;
      start     = 1'b1;
      load_data = ld[3:0];
      mode      = md[2:0];
      count     = cnt[CNT_W-1:0];
      @(posedge clk);
      #1;
      start = 1'b0;
      e0 = cyc;
      v  = ld;
      for (int k = 0; k <= cnt; k++) begin
         trace_q.push_back('{q: v[3:0], dn: (k == cnt)});
         if (k < cnt) v = m_step(v, md);
      end
      se.q   = v[3:0];
      se.cyc = e0 + cnt;
      sb_q.push_back(se);
      n_exp_done++;
      for (int k = 0; k < cnt + 2; k++) begin
         @(negedge clk);
         if (k == inj_k) begin
            start     = 1'b1;
            load_data = ~ld[3:0];
            mode      = 3'($urandom_range(0, 7));
            count     = CNT_W'($urandom_range(0, 7));
         end else begin
            start = 1'b0;
         end
      end
      repeat (gap) @(negedge clk);
   endtask

   task automatic reset_mid_op();
      int v;
      start     = 1'b1;
      load_data = 4'b0110;
      mode      = 3'b110;
      count     = 3'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      v = 6;
      for (int k = 0; k <= 7; k++) begin
         trace_q.push_back('{q: v[3:0], dn: (k == 7)});
         v = m_step(v, 6);
      end
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_q", q, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      trace_q.delete();
      sb_q.delete();
      exp_idle_q = 4'd0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int inj;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_q", q, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      #2;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      run_op(4'b1011, 3'b000, 1, 0, -1);
      run_op(4'b0001, 3'b001, 2, 0, -1);
      run_op(4'b1000, 3'b011, 1, 1, -1);
      run_op(4'b1001, 3'b110, 4, 0, -1);
      run_op(4'b0001, 3'b101, 1, 0, -1);
      run_op(4'b1010, 3'b010, 0, 2, -1);
      run_op(4'b0101, 3'b010, 5, 0, 2);
      run_op(4'b0011, 3'b111, 3, 0, 3);

      reset_mid_op();
      run_op(4'b1100, 3'b100, 3, 0, -1);

      for (int i = 0; i < 40; i++) begin
         cnt = $urandom_range(0, 7);
         inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt)) : -1;
         run_op($urandom_range(0, 15), $urandom_range(0, 7), cnt, $urandom_range(0, 2), inj);
      end

      repeat (3) @(negedge clk);
      #1;
      check("trace_drained", trace_q.size(), 0);
      check("sb_drained", sb_q.size(), 0);
      check("done_count", n_done, n_exp_done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
